// File: rtl/mat_ops_pkg.sv
// Shared definitions for the matrix-ops host and its controller: default
// geometry, RAM row offsets, go-flag location and host state encodings.
package mat_ops_pkg;

    localparam int DEF_DATA_LEN            = 32;
    localparam int DEF_M                   = 8;
    localparam int DEF_N                   = 8;
    localparam int DEF_K                   = 8;
    localparam int DEF_ADDRESS_SIZE        = 4;
    localparam int DEF_READ_A_ADDR_OFFSET  = 8;
    localparam int DEF_READ_B_ADDR_OFFSET  = 0;
    localparam int DEF_WRITE_B_ADDR_OFFSET = 8;

    // Word0 of RAM A row FLAG_ADDR is the go flag; the engine clears it when done.
    localparam int FLAG_ADDR = 0;
    localparam int FLAG_SET  = 1;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LOAD_A    = 4'd1;
    localparam logic [3:0] ST_LOAD_B    = 4'd2;
    localparam logic [3:0] ST_SET_FLAG  = 4'd3;
    localparam logic [3:0] ST_POLL_REQ  = 4'd4;
    localparam logic [3:0] ST_POLL_CHK  = 4'd5;
    localparam logic [3:0] ST_POLL_WAIT = 4'd6;
    localparam logic [3:0] ST_RD_REQ    = 4'd7;
    localparam logic [3:0] ST_RD_CAP    = 4'd8;
    localparam logic [3:0] ST_RD_OUT    = 4'd9;
    localparam logic [3:0] ST_DONE      = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD_A    = ST_LOAD_A,
        S_LOAD_B    = ST_LOAD_B,
        S_SET_FLAG  = ST_SET_FLAG,
        S_POLL_REQ  = ST_POLL_REQ,
        S_POLL_CHK  = ST_POLL_CHK,
        S_POLL_WAIT = ST_POLL_WAIT,
        S_RD_REQ    = ST_RD_REQ,
        S_RD_CAP    = ST_RD_CAP,
        S_RD_OUT    = ST_RD_OUT,
        S_DONE      = ST_DONE
    } host_state_e;

endpackage

// File: rtl/mat_ops_host_if.sv
// Host-side bus bundle: input row stream, result row stream and the second
// ports of RAM A and RAM B. master = host, slave = stream source/sink + RAMs.
interface mat_ops_host_if
    import mat_ops_pkg::*;
#(
    parameter int DATA_LEN     = DEF_DATA_LEN,
    parameter int N            = DEF_N,
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE
);
    localparam int W = DATA_LEN * N;

    logic                    i_in_valid;
    logic                    o_in_ready;
    logic [W-1:0]            i_in_data;
    logic                    o_out_valid;
    logic                    i_out_ready;
    logic [W-1:0]            o_out_data;
    logic [ADDRESS_SIZE-1:0] o_address_A;
    logic                    o_wr_en_A;
    logic [W-1:0]            o_write_data_A;
    logic [W-1:0]            i_read_data_A;
    logic [ADDRESS_SIZE-1:0] o_address_B;
    logic                    o_wr_en_B;
    logic [W-1:0]            o_write_data_B;
    logic [W-1:0]            i_read_data_B;

    modport master (
        input  i_in_valid, i_in_data, i_out_ready, i_read_data_A, i_read_data_B,
        output o_in_ready, o_out_valid, o_out_data,
        output o_address_A, o_wr_en_A, o_write_data_A,
        output o_address_B, o_wr_en_B, o_write_data_B
    );

    modport slave (
        output i_in_valid, i_in_data, i_out_ready, i_read_data_A, i_read_data_B,
        input  o_in_ready, o_out_valid, o_out_data,
        input  o_address_A, o_wr_en_A, o_write_data_A,
        input  o_address_B, o_wr_en_B, o_write_data_B
    );
endinterface

// File: rtl/mat_ops_row_reader.sv
// Result read-out datapath: row counter for the RAM B address, capture
// register for the 1-cycle-latency read data, and the valid/ready hold.
module mat_ops_row_reader #(
    parameter int DATA_LEN            = 32,
    parameter int N                   = 8,
    parameter int ADDRESS_SIZE        = 4,
    parameter int M                   = 8,
    parameter int WRITE_B_ADDR_OFFSET = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       cap_i,        // FSM in RD_CAP
    input  logic                       out_i,        // FSM in RD_OUT
    input  logic                       out_ready_i,
    input  logic [DATA_LEN*N-1:0]      rd_data_i,
    output logic [ADDRESS_SIZE-1:0]    addr_o,
    output logic                       out_valid_o,
    output logic [DATA_LEN*N-1:0]      out_data_o,
    output logic                       accept_o,
    output logic                       last_o
);
    logic [7:0]              rd_cnt_q;
    logic [DATA_LEN*N-1:0]   data_q;

    assign addr_o      = ADDRESS_SIZE'(WRITE_B_ADDR_OFFSET) + ADDRESS_SIZE'(rd_cnt_q);
    assign out_valid_o = out_i;
    assign out_data_o  = data_q;
    assign accept_o    = out_i & out_ready_i;
    assign last_o      = (rd_cnt_q == 8'(M - 1));

    // Capture the row while the RAM presents it; advance the row on accept.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_cnt_q <= '0;
            data_q   <= '0;
        end else begin
            if (cap_i)
                data_q <= rd_data_i;
            if (accept_o)
                rd_cnt_q <= last_o ? 8'd0 : rd_cnt_q + 8'd1;
        end
    end
endmodule

// File: rtl/mat_ops_host.sv
// Host initiator for the matrix-ops engine: loads A and B rows into the RAMs,
// raises the go flag, polls it until cleared, then streams the M result rows.
// Optional macro MAT_OPS_HOST_TIMEOUT_EN bounds the polling phase.
module mat_ops_host
    import mat_ops_pkg::*;
#(
    parameter int DATA_LEN            = DEF_DATA_LEN,
    parameter int M                   = DEF_M,
    parameter int N                   = DEF_N,
    parameter int K                   = DEF_K,
    parameter int ADDRESS_SIZE        = DEF_ADDRESS_SIZE,
    parameter int READ_A_ADDR_OFFSET  = DEF_READ_A_ADDR_OFFSET,
    parameter int READ_B_ADDR_OFFSET  = DEF_READ_B_ADDR_OFFSET,
    parameter int WRITE_B_ADDR_OFFSET = DEF_WRITE_B_ADDR_OFFSET,
    parameter int POLL_GAP            = 4,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_start,
    output logic           o_busy,
    mat_ops_host_if.master bus,
    output logic [3:0]     o_state,
    output logic           o_done,
    output logic           o_timeout
);
    localparam int W = DATA_LEN * N;

    host_state_e             state_q, state_d;
    logic [7:0]              row_cnt_q, row_cnt_d;
    logic [15:0]             gap_cnt_q, gap_cnt_d;
    logic                    in_ready, in_hs, flag_clear, polling, tmo_hit, timeout_q;
    logic                    wr_a, wr_b, rd_accept, rd_last;
    logic [ADDRESS_SIZE-1:0] addr_a, addr_b, rd_addr;
    logic [W-1:0]            wdata_a, wdata_b;
    logic                    unused_rd_a;

    assign in_ready    = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign in_hs       = bus.i_in_valid & in_ready;
    assign flag_clear  = (bus.i_read_data_A[DATA_LEN-1:0] == '0);
    assign polling     = (state_q == S_POLL_REQ) || (state_q == S_POLL_CHK) ||
                         (state_q == S_POLL_WAIT);
    assign unused_rd_a = ^bus.i_read_data_A[W-1:DATA_LEN];

`ifdef MAT_OPS_HOST_TIMEOUT_EN
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic        timeout_d;

    // poll_cnt holds cycles elapsed since SET_FLAG, so DONE lands exactly
    // TIMEOUT_CYCLES cycles after the flag write.
    assign tmo_hit = polling && (poll_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Poll budget counter and sticky timeout flag.
    always_comb begin
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
        if (state_q == S_SET_FLAG)
            poll_cnt_d = 32'd1;
        else if (polling)
            poll_cnt_d = poll_cnt_q + 32'd1;
        if (state_q == S_IDLE && i_start)
            timeout_d = 1'b0;
        else if (tmo_hit)
            timeout_d = 1'b1;
    end

    // Timeout state registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit   = 1'b0;
    assign timeout_q = 1'b0;
`endif

    // Next-state logic and combinational RAM port drive.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        gap_cnt_d = gap_cnt_q;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        addr_a    = '0;
        addr_b    = '0;
        wdata_a   = '0;
        wdata_b   = '0;
        case (state_q)
            S_IDLE:      if (i_start) state_d = S_LOAD_A;
            S_LOAD_A: if (in_hs) begin
                wr_a    = 1'b1;
                addr_a  = ADDRESS_SIZE'(READ_A_ADDR_OFFSET) + ADDRESS_SIZE'(row_cnt_q);
                wdata_a = bus.i_in_data;
                if (row_cnt_q == 8'(M - 1)) begin
                    row_cnt_d = '0;
                    state_d   = S_LOAD_B;
                end else begin
                    row_cnt_d = row_cnt_q + 8'd1;
                end
            end
            S_LOAD_B: if (in_hs) begin
                wr_b    = 1'b1;
                addr_b  = ADDRESS_SIZE'(READ_B_ADDR_OFFSET) + ADDRESS_SIZE'(row_cnt_q);
                wdata_b = bus.i_in_data;
                if (row_cnt_q == 8'(K - 1)) begin
                    row_cnt_d = '0;
                    state_d   = S_SET_FLAG;
                end else begin
                    row_cnt_d = row_cnt_q + 8'd1;
                end
            end
            S_SET_FLAG: begin
                wr_a    = 1'b1;
                addr_a  = ADDRESS_SIZE'(FLAG_ADDR);
                wdata_a = W'(FLAG_SET);
                state_d = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                addr_a  = ADDRESS_SIZE'(FLAG_ADDR);
                state_d = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                gap_cnt_d = '0;
                if (flag_clear)      state_d = S_RD_REQ;
                else if (POLL_GAP == 0) state_d = S_POLL_REQ;
                else                 state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (gap_cnt_q == 16'(POLL_GAP - 1)) state_d = S_POLL_REQ;
                else gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_RD_REQ: begin
                addr_b  = rd_addr;
                state_d = S_RD_CAP;
            end
            S_RD_CAP:    state_d = S_RD_OUT;
            S_RD_OUT:    if (rd_accept) state_d = rd_last ? S_DONE : S_RD_REQ;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (tmo_hit)
            state_d = S_DONE;
    end

    // FSM and load-counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    mat_ops_row_reader #(
        .DATA_LEN(DATA_LEN), .N(N), .ADDRESS_SIZE(ADDRESS_SIZE), .M(M),
        .WRITE_B_ADDR_OFFSET(WRITE_B_ADDR_OFFSET)
    ) u_reader (
        .clk_i(i_clk), .rstn_i(i_rstn),
        .cap_i(state_q == S_RD_CAP), .out_i(state_q == S_RD_OUT),
        .out_ready_i(bus.i_out_ready), .rd_data_i(bus.i_read_data_B),
        .addr_o(rd_addr), .out_valid_o(bus.o_out_valid), .out_data_o(bus.o_out_data),
        .accept_o(rd_accept), .last_o(rd_last)
    );

    assign bus.o_in_ready     = in_ready;
    assign bus.o_address_A    = addr_a;
    assign bus.o_wr_en_A      = wr_a;
    assign bus.o_write_data_A = wdata_a;
    assign bus.o_address_B    = addr_b;
    assign bus.o_wr_en_B      = wr_b;
    assign bus.o_write_data_B = wdata_b;
    assign o_busy             = (state_q != S_IDLE);
    assign o_state            = state_q;
    assign o_done             = (state_q == S_DONE);
    assign o_timeout          = timeout_q;
endmodule

// File: tb/tb_mat_ops_host.sv
// Directed bench for mat_ops_host with RAM A/B models, a model engine that
// clears the go flag, and scoreboards for RAM writes and result rows.
module tb_mat_ops_host;
    import mat_ops_pkg::*;

    localparam int W = 256;
`ifdef MAT_OPS_HOST_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 4096;
`endif

    logic       clk = 1'b0;
    logic       rstn, start;
    logic       busy, done, timeout;
    logic [3:0] state;

    mat_ops_host_if #(.DATA_LEN(32), .N(8), .ADDRESS_SIZE(4)) bus ();

    mat_ops_host #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .o_busy(busy),
        .bus(bus), .o_state(state), .o_done(done), .o_timeout(timeout)
    );

    initial forever #5 clk = ~clk;

    // scoreboards and counters
    logic [287:0] q_wa[$], q_wb[$];
    logic [255:0] q_out[$];
    int           n_vec = 0, n_err = 0, n_done = 0, n_outv = 0, sf_t = 0;
    logic         hold_pend = 1'b0;
    logic [255:0] hold_d;

    // RAM models (second ports) plus model engine clearing the flag
    logic [W-1:0] mem_a[16], mem_b[16];
    logic [W-1:0] rd_a, rd_b;
    int           tcnt = 0, clr_t = 0, eng_cnt = 0;
    logic         eng_en = 1'b1;
    assign bus.i_read_data_A = rd_a;
    assign bus.i_read_data_B = rd_b;

    always @(posedge clk) begin
        tcnt <= tcnt + 1;
        if (tcnt == 0)
            for (int i = 0; i < 8; i++) mem_b[8+i] <= 256'(32'h100 + i);
        if (bus.o_wr_en_A) mem_a[bus.o_address_A] <= bus.o_write_data_A;
        if (bus.o_wr_en_B) mem_b[bus.o_address_B] <= bus.o_write_data_B;
        rd_a <= mem_a[bus.o_address_A];
        rd_b <= mem_b[bus.o_address_B];
        if (bus.o_wr_en_A && bus.o_address_A == 4'd0 && bus.o_write_data_A[31:0] == 32'd1)
            eng_cnt <= 20;
        else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && eng_en) begin
                mem_a[0][31:0] <= 32'd0;
                clr_t          <= tcnt + 1;
            end
        end
    end

    function automatic logic [255:0] row(input int r);
        logic [255:0] v;
        for (int e = 0; e < 8; e++) v[e*32 +: 32] = {8'(r), 8'(e), 16'hC0DE};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sampled mid-cycle: RAM writes, result rows, hold stability, done pulses
    task automatic mon();
        logic [287:0] e;
        if (bus.o_wr_en_A) begin
            if (q_wa.size() == 0) chk("unexpected wrA", 1, 0);
            else begin e = q_wa.pop_front(); chk("wrA", {bus.o_address_A, bus.o_write_data_A}, e); end
        end
        if (bus.o_wr_en_B) begin
            if (q_wb.size() == 0) chk("unexpected wrB", 1, 0);
            else begin e = q_wb.pop_front(); chk("wrB", {bus.o_address_B, bus.o_write_data_B}, e); end
        end
        if (hold_pend) begin
            chk("hold valid", bus.o_out_valid, 1);
            chk("hold data", bus.o_out_data, hold_d);
        end
        hold_pend = bus.o_out_valid && !bus.i_out_ready;
        hold_d    = bus.o_out_data;
        if (bus.o_out_valid) n_outv++;
        if (bus.o_out_valid && bus.i_out_ready) begin
            if (q_out.size() == 0) chk("extra out row", 1, 0);
            else chk("out row", bus.o_out_data, q_out.pop_front());
        end
        if (done) n_done++;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " state"}, state, ST_IDLE);
        chk({tag, " flags"}, {busy, bus.o_in_ready, bus.o_out_valid, bus.o_wr_en_A,
                              bus.o_wr_en_B, done, timeout}, 0);
        chk({tag, " out_data"}, bus.o_out_data, 0);
        chk({tag, " addr"}, {bus.o_address_A, bus.o_address_B}, 0);
        chk({tag, " wdata"}, bus.o_write_data_A | bus.o_write_data_B, 0);
    endtask

    task automatic load_job();
        start = 1'b1; cyc(); start = 1'b0;
        chk("start->LOAD_A", state, ST_LOAD_A);
        for (int r = 0; r < 16; r++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = row(r);
            if (r < 8) q_wa.push_back({4'(8 + r), row(r)});
            else       q_wb.push_back({4'(r - 8), row(r)});
            cyc();
        end
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = '0;
        chk("LOAD->SET_FLAG", state, ST_SET_FLAG);
        sf_t = tcnt;
        q_wa.push_back({4'd0, 256'd1});
        cyc();
        chk("SET_FLAG->POLL_REQ", state, ST_POLL_REQ);
    endtask

    initial begin
        int   t_done, outv0;
        logic poked, ir_chk;
        rstn = 1'b1; start = 1'b0;
        bus.i_in_valid = 1'b0; bus.i_in_data = '0; bus.i_out_ready = 1'b0;
        #2 rstn = 1'b0;
        cyc(); cyc();
        chk_idle_outs("reset");
        rstn = 1'b1;
        cyc();

        // abandon a job mid-LOAD_A after 3 rows
        start = 1'b1; cyc(); start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            bus.i_in_valid = 1'b1; bus.i_in_data = row(r);
            q_wa.push_back({4'(8 + r), row(r)});
            cyc();
        end
        rstn = 1'b0;
        cyc(); cyc();
        chk_idle_outs("mid-load reset");
        chk("wrA queue drained", q_wa.size(), 0);
        bus.i_in_valid = 1'b0;
        rstn = 1'b1;
        cyc();

        // full job
        load_job();
        for (int i = 0; i < 8; i++) begin
            chk("RAM A row", mem_a[8+i], row(i));
            chk("RAM B row", mem_b[i], row(8 + i));
        end
        chk("flag word0", mem_a[0][31:0], 1);

        poked = 1'b0;
        for (int i = 0; i < 200 && state != ST_RD_REQ; i++) begin
            if (clr_t == 0)
                chk("polling while flag set",
                    (state == ST_POLL_REQ || state == ST_POLL_CHK || state == ST_POLL_WAIT), 1);
            if (state == ST_POLL_WAIT && !poked) begin
                start = 1'b1; cyc(); start = 1'b0; poked = 1'b1;
                chk("start ignored in POLL_WAIT",
                    (state == ST_POLL_WAIT || state == ST_POLL_REQ), 1);
            end else cyc();
        end
        chk("reach RD_REQ", state, ST_RD_REQ);
        chk("RD_REQ within 7 of clear", (clr_t != 0) && (tcnt - clr_t <= 7), 1);

        // read-out with ready toggling and a stray input row offered
        bus.i_in_valid = 1'b1; bus.i_in_data = row(99);
        ir_chk = 1'b0;
        for (int i = 0; i < 120 && !(n_done > 0 && state == ST_IDLE); i++) begin
            bus.i_out_ready = ~bus.i_out_ready;
            cyc();
            if (state == ST_RD_OUT && !ir_chk) begin
                chk("in_ready low in RD_OUT", bus.o_in_ready, 0);
                ir_chk = 1'b1;
            end
        end
        bus.i_in_valid = 1'b0; bus.i_out_ready = 1'b0;
        chk("all rows out", q_out.size(), 0);
        chk("done pulses once", n_done, 1);
        chk("back to IDLE", state, ST_IDLE);
        chk("o_timeout low", timeout, 0);

`ifdef MAT_OPS_HOST_TIMEOUT_EN
        eng_en = 1'b0;
        load_job();
        outv0 = n_outv;
        for (int i = 0; i < 200 && state != ST_DONE; i++) cyc();
        t_done = tcnt;
        chk("tmo reach DONE", state, ST_DONE);
        chk("tmo cycles from SET_FLAG", t_done - sf_t, 64);
        chk("o_timeout set", timeout, 1);
        chk("no out_valid on timeout", n_outv - outv0, 0);
        cyc();
        chk("tmo back to IDLE", state, ST_IDLE);
        chk("o_timeout sticky", timeout, 1);
        start = 1'b1; cyc(); start = 1'b0;
        chk("o_timeout cleared by start", timeout, 0);
        rstn = 1'b0; cyc(); rstn = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial for (int i = 0; i < 8; i++) q_out.push_back(256'(32'h100 + i));
endmodule
